// File: rtl/hi_iso14443a_mode_sched_if.sv
// ----------------------------------------------------------------------------
// hi_iso14443a_mode_sched_if
//   Mode-change request handshake between the ARM command path (master) and
//   the ISO14443A mode scheduler (slave). A request transfers on any clock
//   where req_valid and req_ready are both high.
//
//   req_valid  master -> slave  request valid
//   req_mode   master -> slave  requested 3-bit mode
//   req_ready  slave -> master  scheduler can accept a request
// ----------------------------------------------------------------------------
interface hi_iso14443a_mode_sched_if;
  logic       req_valid;
  logic [2:0] req_mode;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_mode,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_mode,
    output req_ready
  );
endinterface

// File: rtl/hi_iso14443a_mode_sched.sv
// ----------------------------------------------------------------------------
// hi_iso14443a_mode_sched
//   Mode scheduler for the ISO14443A HF front end. Accepts mode-change requests
//   from the ARM command path and drives the 3-bit mod_type of the
//   hi_iso14443a datapath. A new mode is applied only on an SSP frame boundary,
//   and a modulating mode is only applied after the front end has spent at
//   least GUARD_CYC cycles in its current mode (listen-before-modulate). A
//   watchdog drops the front end back to its listen mode if frames stop while
//   it is modulating.
//
// Parameters
//   GUARD_CYC    minimum dwell in the current mode before a MOD mode is applied
//   TIMEOUT_CYC  maximum cycles in a MOD mode without a frame edge
//   CW           counter width, 2**CW > max(GUARD_CYC, TIMEOUT_CYC)
//
// Ports
//   ck_1356meg   in   13.56 MHz clock, all logic on its rising edge
//   rst          in   synchronous active-high reset
//   req          if   request handshake (slave side): req_valid/req_mode/req_ready
//   ssp_frame    in   frame strobe from the datapath (ck_1356meg domain)
//   clr_err      in   clears err_illegal
//   mod_type     out  mode driven to the datapath
//   busy         out  a request is pending
//   err_illegal  out  sticky flag, an illegal request was seen
//   timeout_evt  out  one-cycle pulse when the watchdog forces listen mode
//
// Timing
//   ssp_frame is registered on entry, so a frame edge is recognised one cycle
//   after ssp_frame is first sampled high; mod_type therefore moves on the
//   second rising edge at which ssp_frame is seen high.
// ----------------------------------------------------------------------------
module hi_iso14443a_mode_sched #(
  parameter int GUARD_CYC   = 16,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CW          = 13
) (
  input  logic                            ck_1356meg,
  input  logic                            rst,
  hi_iso14443a_mode_sched_if.slave        req,
  input  logic                            ssp_frame,
  input  logic                            clr_err,
  output logic [2:0]                      mod_type,
  output logic                            busy,
  output logic                            err_illegal,
  output logic                            timeout_evt
);

  // --------------------------------------------------------------------------
  // Mode encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] M_SNIFFER       = 3'b000;
  localparam logic [2:0] M_TAG_LISTEN    = 3'b001;
  localparam logic [2:0] M_TAG_MOD       = 3'b010;
  localparam logic [2:0] M_READER_LISTEN = 3'b011;
  localparam logic [2:0] M_READER_MOD    = 3'b100;
  localparam logic [2:0] M_TAG_MOD2      = 3'b101;

  localparam logic [CW-1:0] GUARD_LIM   = CW'(GUARD_CYC);
  localparam logic [CW-1:0] TIMEOUT_LIM = CW'(TIMEOUT_CYC);

  // IDLE : no request pending, handshake open
  // GUARD: MOD request pending, waiting for the listen dwell to complete
  // ALIGN: request pending, waiting for the next frame edge to apply it
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_ALIGN = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Mode classification helpers
  // --------------------------------------------------------------------------
  function automatic logic is_mod(input logic [2:0] m);
    return (m == M_TAG_MOD) || (m == M_READER_MOD) || (m == M_TAG_MOD2);
  endfunction

  // Listen mode of the same family; only meaningful for MOD modes.
  function automatic logic [2:0] family_listen(input logic [2:0] m);
    return (m == M_READER_MOD) ? M_READER_LISTEN : M_TAG_LISTEN;
  endfunction

  // A MOD mode may only be entered from its own family (listen or MOD).
  function automatic logic req_legal(input logic [2:0] r, input logic [2:0] cur);
    logic ok;
    case (r)
      M_TAG_MOD, M_TAG_MOD2:
        ok = (cur == M_TAG_LISTEN) || (cur == M_TAG_MOD) || (cur == M_TAG_MOD2);
      M_READER_MOD:
        ok = (cur == M_READER_LISTEN) || (cur == M_READER_MOD);
      M_SNIFFER, M_TAG_LISTEN, M_READER_LISTEN:
        ok = 1'b1;
      default:
        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // --------------------------------------------------------------------------
  // Internal signals
  // --------------------------------------------------------------------------
  state_t          state;
  state_t          state_nxt;
  logic [2:0]      pend_mode;
  logic            ssp_frame_s;   // ssp_frame registered on entry
  logic            ssp_frame_q;   // ssp_frame_s delayed one cycle
  logic            frame_edge;
  logic [CW-1:0]   dwell;
  logic [CW-1:0]   wdog;
  logic            guard_met;
  logic            timeout_hit;
  logic            accept;
  logic            acc_illegal;
  logic            acc_change;
  logic            apply;
  logic            req_ready_w;
  logic            busy_w;

  assign frame_edge  = ssp_frame_s & ~ssp_frame_q;
  assign guard_met   = (dwell >= GUARD_LIM);
  assign timeout_hit = is_mod(mod_type) && (wdog >= TIMEOUT_LIM);

  // Every accepted request is consumed: illegal ones set the error flag,
  // same-mode ones are no-ops, the rest become the pending request.
  assign accept      = req.req_valid & req_ready_w;
  assign acc_illegal = accept & ~req_legal(req.req_mode, mod_type);
  assign acc_change  = accept &  req_legal(req.req_mode, mod_type) &
                       (req.req_mode != mod_type);

  // A timeout in the same cycle as the aligning frame edge takes priority;
  // the request stays pending for a later edge.
  assign apply = (state == ST_ALIGN) & frame_edge & ~timeout_hit;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the block order.
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  // On a timeout dwell restarts from zero, so any pending request is routed
  // again: MOD requests must sit out a fresh guard, listen requests go
  // straight to alignment. Legality is not re-evaluated.
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // state_nxt unassigned and no latch is inferred.
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (acc_change) begin
          if (timeout_hit) begin
            state_nxt = is_mod(req.req_mode) ? ST_GUARD : ST_ALIGN;
          end else if (is_mod(req.req_mode) && !guard_met) begin
            state_nxt = ST_GUARD;
          end else begin
            state_nxt = ST_ALIGN;
          end
        end
      end
      ST_GUARD: begin
        // Frame edges are deliberately ignored here.
        if (!timeout_hit && guard_met) begin
          state_nxt = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (timeout_hit) begin
          state_nxt = is_mod(pend_mode) ? ST_GUARD : ST_ALIGN;
        end else if (frame_edge) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready_w = 1'b0;
    busy_w      = 1'b1;
    if (state == ST_IDLE) begin
      req_ready_w = 1'b1;
      busy_w      = 1'b0;
    end
  end

  assign req.req_ready = req_ready_w;
  assign busy          = busy_w;

  // --------------------------------------------------------------------------
  // Datapath: frame detect, mode register, counters, flags
  // --------------------------------------------------------------------------
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      ssp_frame_s <= 1'b0;
      ssp_frame_q <= 1'b0;
      pend_mode   <= M_SNIFFER;
      mod_type    <= M_SNIFFER;
      dwell       <= '0;
      wdog        <= '0;
      err_illegal <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      ssp_frame_s <= ssp_frame;
      ssp_frame_q <= ssp_frame_s;

      // Latched once at accept; req_mode is ignored afterwards.
      if (acc_change) begin
        pend_mode <= req.req_mode;
      end

      if (timeout_hit) begin
        mod_type <= family_listen(mod_type);
      end else if (apply) begin
        mod_type <= pend_mode;
      end

      timeout_evt <= timeout_hit;

      // Dwell since the last mode change, saturating at the guard length.
      if (timeout_hit || apply) begin
        dwell <= '0;
      end else if (!guard_met) begin
        dwell <= dwell + CW'(1);
      end

      // Watchdog runs only while modulating and restarts on every frame edge.
      if (timeout_hit || apply || frame_edge) begin
        wdog <= '0;
      end else if (is_mod(mod_type)) begin
        if (wdog < TIMEOUT_LIM) begin
          wdog <= wdog + CW'(1);
        end
      end else begin
        wdog <= '0;
      end

      // A new illegal request outranks a simultaneous clear.
      if (acc_illegal) begin
        err_illegal <= 1'b1;
      end else if (clr_err) begin
        err_illegal <= 1'b0;
      end
    end
  end

endmodule
